tft_spi_tx: RTL and testbench

//  Byte-level sink for the TFT command/data stream produced by the drawing blocks (player, maze, etc.).

---
 rtl/tft_spi_tx_if.sv | 27 ++
 rtl/tft_spi_tx.sv | 200 ++++++++++++++++++++
 tb/tb_tft_spi_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : tft_spi_tx_if
// Purpose  : Producer-side byte stream and flow-control bundle for tft_spi_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface tft_spi_tx_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                          tft_transmit;
    logic                          tft_dc;
    logic [7:0]                    tft_data;
    logic                          tft_busy;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output tft_transmit, tft_dc, tft_data,
        input  tft_busy, overflow, fifo_level
    );

    modport slave (
        input  tft_transmit, tft_dc, tft_data,
        output tft_busy, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/tft_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tft_spi_tx
// Purpose  : FIFO-buffered {dc,data} byte sink serialised to a TFT panel over
//            4-wire SPI mode 0, with busy/overflow flow control.
// Revision : 1.0 - initial release
// ============================================================================
module tft_spi_tx #(
    parameter int CLK_DIV        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int CS_IDLE_CYCLES = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    tft_spi_tx_if.slave  bus,
    output logic         spi_sck_o,
    output logic         spi_mosi_o,
    output logic         spi_dc_o,
    output logic         spi_cs_n_o
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = $clog2(CLK_DIV + 1);
    localparam int c_IW = $clog2(CS_IDLE_CYCLES + 1);

    localparam logic [c_LW-1:0] c_FULL      = c_LW'(FIFO_DEPTH);
    localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);
    localparam logic [c_IW-1:0] c_IDLE_LAST = c_IW'(CS_IDLE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_LW-1:0] level_q, level_d;
    logic            busy_q, ovf_q;

    logic [1:0]      state_q, state_d;
    logic [c_DW-1:0] div_q, div_d;
    logic [c_IW-1:0] idle_q, idle_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            sck_q, sck_d;
    logic            dc_q, dc_d;
    logic            cs_n_q, cs_n_d;

    logic            w_empty, w_full, w_push, w_pop, w_phase_end;
    logic [8:0]      w_head;

    assign w_empty     = (level_q == '0);
    assign w_full      = (level_q == c_FULL);
    // A write at full is still accepted when the serializer frees a slot that same cycle.
    assign w_push      = bus.tft_transmit & (~w_full | w_pop);
    assign w_head      = mem_q[rd_ptr_q];
    assign w_phase_end = (div_q == c_DIV_LAST);
    assign level_d     = level_q + c_LW'(w_push) - c_LW'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (!w_empty) state_d = c_ST_SETUP;
            c_ST_SETUP: if (w_phase_end) state_d = c_ST_SHIFT;
            c_ST_SHIFT: if (w_phase_end && sck_q && bit_q == 3'd7 && w_empty) state_d = c_ST_HOLD;
            c_ST_HOLD: begin
                if (!w_empty)                  state_d = c_ST_SETUP;
                else if (idle_q == c_IDLE_LAST) state_d = c_ST_IDLE;
            end
            default:    state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        div_d   = div_q;
        idle_d  = idle_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        dc_d    = dc_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            c_ST_IDLE: begin
                sck_d  = 1'b0;
                cs_n_d = 1'b1;
                div_d  = '0;
                idle_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_head[7:0];
                    dc_d    = w_head[8];
                    bit_d   = 3'd0;
                    cs_n_d  = 1'b0;
                end
            end
            c_ST_SETUP: begin
                if (w_phase_end) begin
                    div_d = '0;
                    sck_d = 1'b1;
                end else begin
                    div_d = div_q + c_DW'(1);
                end
            end
            c_ST_SHIFT: begin
                if (!w_phase_end) begin
                    div_d = div_q + c_DW'(1);
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    // Falling edge: advance the bit, or chain the next byte without a gap.
                    if (sck_q) begin
                        if (bit_q != 3'd7) begin
                            bit_d   = bit_q + 3'd1;
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end else if (!w_empty) begin
                            w_pop   = 1'b1;
                            shreg_d = w_head[7:0];
                            dc_d    = w_head[8];
                            bit_d   = 3'd0;
                        end else begin
                            idle_d = '0;
                        end
                    end
                end
            end
            c_ST_HOLD: begin
                sck_d = 1'b0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_head[7:0];
                    dc_d    = w_head[8];
                    bit_d   = 3'd0;
                    div_d   = '0;
                    idle_d  = '0;
                end else if (idle_q == c_IDLE_LAST) begin
                    cs_n_d = 1'b1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + c_IW'(1);
                end
            end
            default: begin
                sck_d  = 1'b0;
                cs_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= '0;
            idle_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sck_q    <= 1'b0;
            dc_q     <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            idle_q   <= idle_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sck_q    <= sck_d;
            dc_q     <= dc_d;
            cs_n_q   <= cs_n_d;
            level_q  <= level_d;
            busy_q   <= (level_d == c_FULL);
            ovf_q    <= ovf_q | (bus.tft_transmit & ~w_push);
            if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) mem_q[wr_ptr_q] <= {bus.tft_dc, bus.tft_data};
    end

    assign spi_sck_o      = sck_q;
    assign spi_mosi_o     = shreg_q[7];
    assign spi_dc_o       = dc_q;
    assign spi_cs_n_o     = cs_n_q;
    assign bus.tft_busy   = busy_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = level_q;
endmodule
`default_nettype wire

// File: tb/tb_tft_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_spi_tx
// Purpose  : Directed self-checking bench for tft_spi_tx with an SPI byte monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_spi_tx;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CS_IDLE    = 16;
    localparam int N_STREAM   = 1452;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic mon_clr = 1'b1;
    logic spi_sck_o, spi_mosi_o, spi_dc_o, spi_cs_n_o;

    always #5 clk = ~clk;

    tft_spi_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    tft_spi_tx #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CS_IDLE_CYCLES(CS_IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .spi_sck_o(spi_sck_o),
        .spi_mosi_o(spi_mosi_o),
        .spi_dc_o(spi_dc_o),
        .spi_cs_n_o(spi_cs_n_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // SPI monitor: rebuilds {dc,byte} from sck rising edges and tracks line discipline.
    int   cyc = 0, rises = 0, bitc = 0, cap_cnt = 0, viol = 0, dc_hi = 0, cs_rises = 0;
    int   last_rise = -1, last_fall = 0, cs_rise = 0, min_gap = 1000, max_gap = 0;
    logic prev_sck = 1'b0, prev_dc = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
    logic [7:0] sh = '0;
    logic [8:0] cap [0:2047];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sck  <= spi_sck_o;
        prev_dc   <= spi_dc_o;
        prev_mosi <= spi_mosi_o;
        prev_cs   <= spi_cs_n_o;
        if (mon_clr) begin
            rises <= 0; bitc <= 0; cap_cnt <= 0; viol <= 0; dc_hi <= 0; cs_rises <= 0;
            last_rise <= -1; min_gap <= 1000; max_gap <= 0;
        end else begin
            if (spi_sck_o && !prev_sck) begin
                rises <= rises + 1;
                sh    <= {sh[6:0], spi_mosi_o};
                if (spi_dc_o) dc_hi <= dc_hi + 1;
                if (bitc == 7) begin
                    cap[11'(cap_cnt)] <= {spi_dc_o, sh[6:0], spi_mosi_o};
                    cap_cnt <= cap_cnt + 1;
                    bitc    <= 0;
                end else begin
                    bitc <= bitc + 1;
                end
                if (last_rise >= 0) begin
                    if (cyc - last_rise > max_gap) max_gap <= cyc - last_rise;
                    if (cyc - last_rise < min_gap) min_gap <= cyc - last_rise;
                end
                last_rise <= cyc;
            end
            if (!spi_sck_o && prev_sck) last_fall <= cyc;
            if (spi_cs_n_o && !prev_cs) begin
                cs_rise  <= cyc;
                cs_rises <= cs_rises + 1;
            end
            if (spi_sck_o && (spi_dc_o != prev_dc || spi_mosi_o != prev_mosi || spi_cs_n_o))
                viol <= viol + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic send(input logic dc, input logic [7:0] d);
        bus.tft_transmit = 1'b1;
        bus.tft_dc       = dc;
        bus.tft_data     = d;
        tick();
        bus.tft_transmit = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (!(cap_cnt == n && spi_cs_n_o === 1'b1) && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int n, input int budget);
        int k = 0;
        while (rises < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    function automatic logic [8:0] pat(input int i);
        logic [7:0] d;
        d = 8'((i * 37 + 11) & 255);
        return {(i % 3) != 0, d};
    endfunction

    logic [8:0] w;
    int         r0, stalls, k6;

    initial begin
        bus.tft_transmit = 1'b0;
        bus.tft_dc       = 1'b0;
        bus.tft_data     = 8'h00;
        repeat (3) tick();
        check("rst_sck",   32'(spi_sck_o),        32'd0);
        check("rst_mosi",  32'(spi_mosi_o),       32'd0);
        check("rst_dc",    32'(spi_dc_o),         32'd0);
        check("rst_cs_n",  32'(spi_cs_n_o),       32'd1);
        check("rst_busy",  32'(bus.tft_busy),     32'd0);
        check("rst_ovf",   32'(bus.overflow),     32'd0);
        check("rst_level", 32'(bus.fifo_level),   32'd0);
        rst = 1'b1;
        clr_mon();

        // Single command byte: latency, bit order, CS release timing.
        send(1'b0, 8'h2A);
        check("t2_level1", 32'(bus.fifo_level), 32'd1);
        check("t2_cs_hi",  32'(spi_cs_n_o),     32'd1);
        tick();
        check("t2_cs_lo",  32'(spi_cs_n_o),     32'd0);
        check("t2_level0", 32'(bus.fifo_level), 32'd0);
        tick();
        check("t2_setup",  32'(spi_sck_o),      32'd0);
        tick();
        check("t2_rise",   32'(spi_sck_o),      32'd1);
        wait_done("t2_done", 1, 200);
        check("t2_byte",   32'(cap[0]),   32'h02A);
        check("t2_rises",  32'(rises),    32'd8);
        check("t2_dc_hi",  32'(dc_hi),    32'd0);
        check("t2_viol",   32'(viol),     32'd0);
        check("t2_cs_rel", 32'(cs_rise - last_fall), 32'(CS_IDLE));

        // Three back-to-back bytes: one continuous SCK train.
        clr_mon();
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00);
        send(1'b1, 8'h05);
        wait_done("t3_done", 3, 400);
        check("t3_b0",     32'(cap[0]),   32'h02A);
        check("t3_b1",     32'(cap[1]),   32'h100);
        check("t3_b2",     32'(cap[2]),   32'h105);
        check("t3_rises",  32'(rises),    32'd24);
        check("t3_dc_hi",  32'(dc_hi),    32'd16);
        check("t3_mingap", 32'(min_gap),  32'(2 * CLK_DIV));
        check("t3_maxgap", 32'(max_gap),  32'(2 * CLK_DIV));
        check("t3_csrel",  32'(cs_rises), 32'd1);
        check("t3_viol",   32'(viol),     32'd0);

        // Overflow: five strobes while the serializer is mid-byte.
        clr_mon();
        send(1'b0, 8'h3C);
        wait_rises("t4_start", 1, 50);
        send(1'b1, 8'hA1);
        send(1'b0, 8'hA2);
        send(1'b1, 8'hA3);
        check("t4_busy3",   32'(bus.tft_busy),   32'd0);
        send(1'b0, 8'hA4);
        check("t4_busy4",   32'(bus.tft_busy),   32'd1);
        check("t4_level4",  32'(bus.fifo_level), 32'd4);
        check("t4_ovf_pre", 32'(bus.overflow),   32'd0);
        send(1'b1, 8'hA5);
        check("t4_ovf",     32'(bus.overflow),   32'd1);
        check("t4_level5",  32'(bus.fifo_level), 32'd4);
        wait_done("t4_done", 5, 600);
        check("t4_count",   32'(cap_cnt), 32'd5);
        check("t4_b0",      32'(cap[0]),  32'h03C);
        check("t4_b1",      32'(cap[1]),  32'h1A1);
        check("t4_b2",      32'(cap[2]),  32'h0A2);
        check("t4_b3",      32'(cap[3]),  32'h1A3);
        check("t4_b4",      32'(cap[4]),  32'h0A4);

        // Push coinciding with the pop that ends the current byte while full.
        clr_mon();
        send(1'b0, 8'h11);
        wait_rises("t5_start", 1, 50);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        send(1'b1, 8'h44);
        send(1'b1, 8'h55);
        check("t5_full",    32'(bus.fifo_level), 32'd4);
        wait_rises("t5_bit8", 8, 100);
        repeat (CLK_DIV - 1) tick();
        check("t5_pre_lvl", 32'(bus.fifo_level), 32'd4);
        send(1'b0, 8'h66);
        check("t5_level",   32'(bus.fifo_level), 32'd4);
        check("t5_busy",    32'(bus.tft_busy),   32'd1);
        check("t5_sck_lo",  32'(spi_sck_o),      32'd0);
        wait_done("t5_done", 6, 800);
        check("t5_count",   32'(cap_cnt), 32'd6);
        check("t5_b0",      32'(cap[0]),  32'h011);
        check("t5_b1",      32'(cap[1]),  32'h122);
        check("t5_b2",      32'(cap[2]),  32'h133);
        check("t5_b3",      32'(cap[3]),  32'h144);
        check("t5_b4",      32'(cap[4]),  32'h155);
        check("t5_b5",      32'(cap[5]),  32'h066);

        // Reset in the middle of the 4th bit with a full FIFO.
        clr_mon();
        repeat (6) send(1'b1, 8'hFF);
        check("t1_busy_pre", 32'(bus.tft_busy), 32'd1);
        check("t1_ovf_pre",  32'(bus.overflow), 32'd1);
        wait_rises("t1_bit4", 4, 50);
        check("t1_sck_hi",   32'(spi_sck_o), 32'd1);
        rst = 1'b0;
        repeat (3) tick();
        check("t1_cs_n",  32'(spi_cs_n_o),      32'd1);
        check("t1_sck",   32'(spi_sck_o),       32'd0);
        check("t1_level", 32'(bus.fifo_level),  32'd0);
        check("t1_busy",  32'(bus.tft_busy),    32'd0);
        check("t1_ovf",   32'(bus.overflow),    32'd0);
        rst = 1'b1;
        r0 = rises;
        repeat (40) tick();
        check("t1_quiet", 32'(rises),      32'(r0));
        check("t1_cs_n2", 32'(spi_cs_n_o), 32'd1);

        // Long stream obeying busy.
        clr_mon();
        stalls = 0;
        for (int i = 0; i < N_STREAM; i++) begin
            k6 = 0;
            while (bus.tft_busy === 1'b1 && k6 < 100) begin
                tick();
                k6++;
            end
            if (k6 >= 100) stalls++;
            w = pat(i);
            send(w[8], w[7:0]);
        end
        wait_done("t6_done", N_STREAM, 300);
        check("t6_stalls", 32'(stalls),       32'd0);
        check("t6_count",  32'(cap_cnt),      32'(N_STREAM));
        check("t6_ovf",    32'(bus.overflow), 32'd0);
        check("t6_viol",   32'(viol),         32'd0);
        check("t6_mingap", 32'(min_gap),      32'(2 * CLK_DIV));
        check("t6_maxgap", 32'(max_gap),      32'(2 * CLK_DIV));
        for (int i = 0; i < N_STREAM; i++) check("t6_byte", 32'(cap[11'(i)]), 32'(pat(i)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
